fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_write_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo write arbiter: FSM state encoding
// and the stall counter width and saturation value.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1
    } state_t;

    localparam int          STALL_W   = 16;
    localparam logic [15:0] STALL_SAT = 16'hFFFF;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above the
// start index, wrapping from the top index back to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   start,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    always_comb begin
        int idx;
        pick  = '0;
        valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter with locked bursts in front of a single fifo port.
// Optional stall counter output enabled by defining FIFO_ARB_STALL_CNT_EN.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          in_clock,
    input  logic                          in_reset,
    input  logic [NUM_REQ-1:0]            in_req,
    input  logic [NUM_REQ-1:0]            in_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic                          in_full,
    output logic [NUM_REQ-1:0]            out_grant,
    output logic                          out_put,
    output logic [DATA_WIDTH-1:0]         out_data,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [STALL_W-1:0]            out_stall_count,
`endif
    output logic                          out_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   count_inc;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] grant;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
        .req   (in_req),
        .start (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
    endfunction

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        count_d = count_q;
        grant   = '0;
        // A full fifo freezes everything, including a pending burst exit.
        if (!in_reset && !in_full) begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant = pick;
                        ptr_d = wrap_inc(pick_idx);
                        if (in_lock[pick_idx] && (MAX_BURST > 1)) begin
                            state_d = BURST;
                            owner_d = pick_idx;
                            count_d = CNT_W'(1);
                        end
                    end
                end
                BURST: begin
                    ptr_d = wrap_inc(owner_q);
                    if (in_req[owner_q]) begin
                        grant[owner_q] = 1'b1;
                        count_d        = count_inc;
                        if ((count_inc == CNT_W'(MAX_BURST)) || !in_lock[owner_q]) begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    end else begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) out_data = out_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign out_grant = grant;
    assign out_put   = |grant;
    assign out_busy  = (state_q == BURST) && !in_reset;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            stall_q <= '0;
        end else if ((|in_req) && in_full && (stall_q != STALL_SAT)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign out_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4),
// including a 16-entry fifo occupancy model for the back-pressure sequence.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data_in;
    logic        full_force;
    logic        use_fifo;
    logic        fifo_clr;
    logic        full;
    logic [3:0]  grant;
    logic        put;
    logic [7:0]  data_out;
    logic        busy;
    logic [4:0]  fifo_cnt;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;
    int writes;

    always #5 clk = ~clk;

    assign full = use_fifo ? (fifo_cnt == 5'd16) : full_force;

    always @(posedge clk) begin
        if (fifo_clr) fifo_cnt <= 5'd0;
        else if (put && !full) fifo_cnt <= fifo_cnt + 5'd1;
    end

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .in_clock  (clk),
        .in_reset  (rst),
        .in_req    (req),
        .in_lock   (lock),
        .in_data   (data_in),
        .in_full   (full),
        .out_grant (grant),
        .out_put   (put),
        .out_data  (data_out),
`ifdef FIFO_ARB_STALL_CNT_EN
        .out_stall_count (stall_count),
`endif
        .out_busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check grant, put, data and busy for the current (combinational) cycle.
    task automatic expect_cycle(input string tag, input logic [3:0] g, input logic b);
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 4; i++) if (g[i]) d = 8'hA0 + 8'(i);
        chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
        chk({tag, ".put"},   {31'd0, put},   {31'd0, |g});
        chk({tag, ".data"},  {24'd0, data_out}, {24'd0, d});
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; lock = 4'b1111; full_force = 1'b0;
        use_fifo = 1'b0; fifo_clr = 1'b1;
        data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        cyc();
        #3 expect_cycle("reset", 4'b0000, 1'b0);
        cyc();
        rst = 1'b0; fifo_clr = 1'b0; lock = 4'b0000;

        // Plain round robin from pointer 0.
        #3 expect_cycle("rr0", 4'b0001, 1'b0); cyc();
        #3 expect_cycle("rr1", 4'b0010, 1'b0); cyc();
        #3 expect_cycle("rr2", 4'b0100, 1'b0); cyc();
        #3 expect_cycle("rr3", 4'b1000, 1'b0); cyc();
        #3 expect_cycle("rr4", 4'b0001, 1'b0); cyc();

        // Move pointer to 2, then producer 2 bursts for MAX_BURST beats.
        req = 4'b0010;
        #3 expect_cycle("pre_b2", 4'b0010, 1'b0); cyc();
        req = 4'b1111; lock = 4'b0100;
        #3 expect_cycle("b2_beat1", 4'b0100, 1'b0); cyc();
        #3 expect_cycle("b2_beat2", 4'b0100, 1'b1); cyc();
        #3 expect_cycle("b2_beat3", 4'b0100, 1'b1); cyc();
        #3 expect_cycle("b2_beat4", 4'b0100, 1'b1); cyc();
        #3 expect_cycle("b2_after", 4'b1000, 1'b0); cyc();
        #3 expect_cycle("b2_wrap",  4'b0001, 1'b0); cyc();

        // Producer 1 burst interrupted by 3 full cycles.
        lock = 4'b0010;
        #3 expect_cycle("b1_beat1", 4'b0010, 1'b0); cyc();
        #3 expect_cycle("b1_beat2", 4'b0010, 1'b1); cyc();
        full_force = 1'b1;
        #3 expect_cycle("b1_full0", 4'b0000, 1'b1); cyc();
        #3 expect_cycle("b1_full1", 4'b0000, 1'b1); cyc();
        #3 expect_cycle("b1_full2", 4'b0000, 1'b1); cyc();
        full_force = 1'b0;
        #3 expect_cycle("b1_beat3", 4'b0010, 1'b1); cyc();
        #3 expect_cycle("b1_beat4", 4'b0010, 1'b1); cyc();
        #3 expect_cycle("b1_after", 4'b0100, 1'b0); cyc();

        // Reset during beat 2 of a producer 3 burst.
        lock = 4'b1000;
        #3 expect_cycle("b3_beat1", 4'b1000, 1'b0); cyc();
        rst = 1'b1;
        #3 expect_cycle("b3_reset", 4'b0000, 1'b0); cyc();
        rst = 1'b0; lock = 4'b0000;
        #3 expect_cycle("post_reset", 4'b0001, 1'b0); cyc();

        // Owner drops its request mid-burst: one idle cycle, then arbitration.
        req = 4'b0010; lock = 4'b0010;
        #3 expect_cycle("drop_beat1", 4'b0010, 1'b0); cyc();
        req = 4'b0101; lock = 4'b0000;
        #3 expect_cycle("drop_exit", 4'b0000, 1'b1); cyc();
        #3 expect_cycle("drop_next", 4'b0100, 1'b0); cyc();

        // Fill a 16-entry fifo with no reads.
        rst = 1'b1; fifo_clr = 1'b1; use_fifo = 1'b1; req = 4'b0011;
        cyc();
        rst = 1'b0; fifo_clr = 1'b0;
`ifdef FIFO_ARB_STALL_CNT_EN
        #3 chk("stall_reset", {16'd0, stall_count}, 32'd0);
`else
        #3;
`endif
        expect_cycle("fill0", 4'b0001, 1'b0);
        writes = 0;
        for (int c = 0; c < 20; c++) begin
            if (put) writes++;
            cyc();
            #3;
        end
        chk("fill_writes", 32'(writes), 32'd16);
        expect_cycle("fill_blocked", 4'b0000, 1'b0);
`ifdef FIFO_ARB_STALL_CNT_EN
        chk("stall_count", {16'd0, stall_count}, 32'd4);
        cyc();
        #3 chk("stall_count_inc", {16'd0, stall_count}, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
